riscv_mem_port_arbiter: RTL

//   Shares one single-ported synchronous memory between the IF stage (instruction

---
 rtl/riscv_mem_port_arbiter_if.sv | 45 ++++
 rtl/riscv_mem_port_arbiter.sv | 119 +++++++++++
 2 files changed

// File: rtl/riscv_mem_port_arbiter_if.sv
// Request/response and memory-side bus of the IF/MEM shared-memory arbiter.
// The slave modport is the arbiter; the master modport is the pipeline plus the memory.
interface riscv_mem_port_arbiter_if;
    logic        if_req_valid;
    logic [31:0] if_req_addr;
    logic        if_req_ready;
    logic        if_resp_valid;
    logic [31:0] if_resp_data;

    logic        dm_req_valid;
    logic        dm_req_we;
    logic [31:0] dm_req_addr;
    logic [31:0] dm_req_wdata;
    logic        dm_req_ready;
    logic        dm_resp_valid;
    logic [31:0] dm_resp_data;

    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        busy;

    modport slave (
        input  if_req_valid, if_req_addr,
        input  dm_req_valid, dm_req_we, dm_req_addr, dm_req_wdata,
        input  mem_rdata,
        output if_req_ready, if_resp_valid, if_resp_data,
        output dm_req_ready, dm_resp_valid, dm_resp_data,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output busy
    );

    modport master (
        output if_req_valid, if_req_addr,
        output dm_req_valid, dm_req_we, dm_req_addr, dm_req_wdata,
        output mem_rdata,
        input  if_req_ready, if_resp_valid, if_resp_data,
        input  dm_req_ready, dm_resp_valid, dm_resp_data,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  busy
    );
endinterface

// File: rtl/riscv_mem_port_arbiter.sv
// Shares one single-ported synchronous memory between IF fetches and MEM loads/stores.
// One access in flight; data wins conflicts, bounded by a starvation counter for IF.
module riscv_mem_port_arbiter #(
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 2
) (
    input logic                      clock,
    input logic                      reset_n,
    riscv_mem_port_arbiter_if.slave  bus
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [2:0] WAIT_INIT  = 3'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t     state;
    logic [3:0] starve_cnt;
    logic [2:0] wait_cnt;
    logic       owner_dm;
    logic       we_q;

    logic       grant_window;
    logic       if_wins;
    logic       if_ready;
    logic       dm_ready;

    always_comb begin
        grant_window = (state == ST_IDLE) || (state == ST_RESP);
        if_wins      = bus.if_req_valid && (!bus.dm_req_valid || (starve_cnt == STARVE_MAX));
        if_ready     = grant_window && if_wins;
        dm_ready     = grant_window && bus.dm_req_valid && !if_wins;
    end

    assign bus.if_req_ready = if_ready;
    assign bus.dm_req_ready = dm_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state             <= ST_IDLE;
            starve_cnt        <= '0;
            wait_cnt          <= '0;
            owner_dm          <= 1'b0;
            we_q              <= 1'b0;
            bus.mem_en        <= 1'b0;
            bus.mem_we        <= 1'b0;
            bus.mem_addr      <= '0;
            bus.mem_wdata     <= '0;
            bus.busy          <= 1'b0;
            bus.if_resp_valid <= 1'b0;
            bus.if_resp_data  <= '0;
            bus.dm_resp_valid <= 1'b0;
            bus.dm_resp_data  <= '0;
        end else begin
            // Strobes and response pulses default low; each state re-asserts what it owns.
            bus.mem_en        <= 1'b0;
            bus.mem_we        <= 1'b0;
            bus.mem_addr      <= '0;
            bus.mem_wdata     <= '0;
            bus.busy          <= 1'b0;
            bus.if_resp_valid <= 1'b0;
            bus.dm_resp_valid <= 1'b0;

            case (state)
                ST_IDLE, ST_RESP: begin
                    if (if_ready || dm_ready) begin
                        state         <= ST_ISSUE;
                        owner_dm      <= dm_ready;
                        we_q          <= dm_ready && bus.dm_req_we;
                        bus.mem_en    <= 1'b1;
                        bus.mem_we    <= dm_ready && bus.dm_req_we;
                        bus.mem_addr  <= dm_ready ? bus.dm_req_addr : bus.if_req_addr;
                        bus.mem_wdata <= dm_ready ? bus.dm_req_wdata : '0;
                        bus.busy      <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end

                    if (if_ready) begin
                        starve_cnt <= '0;
                    end else if (dm_ready && bus.if_req_valid && (starve_cnt != STARVE_MAX)) begin
                        starve_cnt <= starve_cnt + 4'd1;
                    end
                end

                ST_ISSUE: begin
                    state    <= ST_WAIT;
                    wait_cnt <= WAIT_INIT;
                    bus.busy <= 1'b1;
                end

                ST_WAIT: begin
                    // The last WAIT cycle is the one in which mem_rdata is valid.
                    if (wait_cnt == 3'd0) begin
                        state <= ST_RESP;
                        if (owner_dm) begin
                            bus.dm_resp_valid <= 1'b1;
                            bus.dm_resp_data  <= we_q ? '0 : bus.mem_rdata;
                        end else begin
                            bus.if_resp_valid <= 1'b1;
                            bus.if_resp_data  <= bus.mem_rdata;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                        bus.busy <= 1'b1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
